pipelined_cla_addsub: RTL
=========================

Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined N-bit adder/subtractor built from 4-bit carry-lookahead slices. The operand word is split into pipeline segments of STAGE_BITS bits. Each segment resolves its carries internally with lookahead groups and passes its carry to the next stage through a register. Valid/ready handshakes on both sides let it sit in the ALU datapath between the operand-fetch register and the writeback register, with backpressure support.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGE_BITS.
STAGE_BITS, 8, bits resolved per pipeline stage; must be a multiple of 4.
NSTAGES, WIDTH/STAGE_BITS (derived localparam, not overridable), pipeline depth and latency in cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced to 1, cin ignored)
cin  input  1  carry-in for add mode
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (in sub mode: 1 = no borrow)
ovf  output  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB
zero  output  1  sum == 0

Behaviour:
- Reset (rst high at a clk edge): all stage valid bits cleared; out_valid=0; sum=0, cout=0, ovf=0, zero=0. In-flight operations are discarded, not completed.
- Global stall: advance = !out_valid || out_ready. in_ready = advance, which is combinational from out_ready. When advance=0, every stage register holds.
- Transfer in: an operand is taken when in_valid && in_ready. Stage 0 valid is loaded with in_valid on every advance, so bubbles propagate. Bubbles are not collapsed.
- Stage k (0..NSTAGES-1) computes bits [k*STAGE_BITS +: STAGE_BITS]:
  - inputs are the registered slice of A, the conditionally inverted slice of B, and the carry register from stage k-1 (stage 0 uses sub ? 1 : cin);
  - the slice is built from STAGE_BITS/4 CLA groups of 4 bits, each with generate/propagate lookahead internally;
  - group carries ripple between groups within the stage.
- Unresolved upper operand bits and resolved lower sum bits are carried forward in per-stage skew registers.
- Latency: exactly NSTAGES cycles from accept to out_valid when there is no stall. Throughput is one result per cycle.
- Flags come from the final stage:
  - cout is the MSB group carry-out;
  - ovf uses the carry into bit WIDTH-1;
  - zero is computed over the full registered sum.
- Output registers hold their value while out_valid && !out_ready.
- When out_valid=0, sum and flags hold their last values (no guarantee beyond being stable).
- NSTAGES=1 is legal: a single registered stage with latency 1.
- Wrap-around: results are modulo 2^WIDTH; cout/ovf report the overflow. No saturation.
- Simultaneous in_valid with a stall: not accepted; in_ready=0, and the source must hold its operands.

Test Plan (WIDTH=16, STAGE_BITS=8, so NSTAGES=2):
1. Reset, then a=0x1234, b=0x4321, sub=0, cin=0 accepted at cycle 0 -> out_valid at cycle 2 with sum=0x5555, cout=0, ovf=0, zero=0.
2. a=0x00FF, b=0x0001, add, followed back-to-back by a=0xFFFF, b=0x0001 -> results 0x0100 (cross-stage carry, cout=0), then 0x0000 with cout=1, zero=1, on consecutive cycles.
3. sub: a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1; a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0.
4. Add a=0x7FFF, b=0x0001, cin=1 -> sum=0x8001, ovf=1. Random 1000 vectors compared against the behavioural A±B, including random bubbles.
5. Backpressure: out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, outputs stable, no loss or duplication; the release yields the original order.
6. Assert rst with two operations in flight -> out_valid=0 the next cycle, and neither result ever appears.

Source files
------------

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipelined_cla_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined N-bit adder/subtractor: each stage resolves STAGE_BITS bits with rippled 4-bit CLA
// groups and hands its carry plus skewed operand/sum words to the next stage.
module pipelined_cla_addsub #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned STAGE_BITS = 8
) (
   input logic                   clk,
   input logic                   rst,
   pipelined_cla_addsub_if.slave bus
);
   localparam int unsigned NSTAGES = WIDTH / STAGE_BITS;
   localparam int unsigned NGROUPS = STAGE_BITS / 4;

   typedef struct packed {
      logic [STAGE_BITS-1:0] s;
      logic                  co;
      logic                  cmsb;
   } slice_t;

   // cmsb is the carry into the top bit of the slice, needed for signed overflow.
   function automatic slice_t cla_slice(input logic [STAGE_BITS-1:0] x,
                                        input logic [STAGE_BITS-1:0] y,
                                        input logic                  ci);
      slice_t     r;
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      logic       gc;
      r  = '0;
      gc = ci;
      for (int grp = 0; grp < int'(NGROUPS); grp++) begin
         g    = x[grp*4 +: 4] & y[grp*4 +: 4];
         p    = x[grp*4 +: 4] ^ y[grp*4 +: 4];
         c[0] = gc;
         c[1] = g[0] | (p[0] & c[0]);
         c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
         c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
         c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
         r.s[grp*4 +: 4] = p ^ c[3:0];
         r.cmsb          = c[3];
         gc              = c[4];
      end
      r.co = gc;
      return r;
   endfunction

   logic               advance;
   logic [NSTAGES-1:0] vld_d, vld_q;
   logic [NSTAGES-1:0] c_d, c_q;
   logic [WIDTH-1:0]   a_d  [NSTAGES];
   logic [WIDTH-1:0]   a_q  [NSTAGES];
   logic [WIDTH-1:0]   bx_d [NSTAGES];
   logic [WIDTH-1:0]   bx_q [NSTAGES];
   logic [WIDTH-1:0]   s_d  [NSTAGES];
   logic [WIDTH-1:0]   s_q  [NSTAGES];
   logic               ovf_d, ovf_q;
   logic               zero_d, zero_q;

   assign advance      = !vld_q[NSTAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;

   for (genvar k = 0; k < int'(NSTAGES); k++) begin : g_stage
      logic [WIDTH-1:0] a_in, bx_in, s_in, s_new;
      logic             c_in, v_in;
      slice_t           r;

      if (k == 0) begin : g_first
         assign a_in  = bus.a;
         assign bx_in = bus.sub ? ~bus.b : bus.b;
         assign c_in  = bus.sub | bus.cin;
         assign s_in  = '0;
         assign v_in  = bus.in_valid;
      end else begin : g_next
         assign a_in  = a_q[k-1];
         assign bx_in = bx_q[k-1];
         assign c_in  = c_q[k-1];
         assign s_in  = s_q[k-1];
         assign v_in  = vld_q[k-1];
      end

      assign r = cla_slice(a_in[k*STAGE_BITS +: STAGE_BITS], bx_in[k*STAGE_BITS +: STAGE_BITS],
                           c_in);

      always_comb begin
         s_new                              = s_in;
         s_new[k*STAGE_BITS +: STAGE_BITS] = r.s;
      end

      assign a_d[k]  = a_in;
      assign bx_d[k] = bx_in;
      assign s_d[k]  = s_new;
      assign c_d[k]  = r.co;
      assign vld_d[k] = v_in;

      if (k == int'(NSTAGES) - 1) begin : g_last
         assign ovf_d  = r.cmsb ^ r.co;
         assign zero_d = (s_new == '0);
      end
   end

   // Data registers only load on a valid slot so outputs stay stable across bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         c_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < int'(NSTAGES); k++) begin
            a_q[k]  <= '0;
            bx_q[k] <= '0;
            s_q[k]  <= '0;
         end
      end else if (advance) begin
         vld_q <= vld_d;
         for (int k = 0; k < int'(NSTAGES); k++) begin
            if (vld_d[k]) begin
               a_q[k]  <= a_d[k];
               bx_q[k] <= bx_d[k];
               s_q[k]  <= s_d[k];
               c_q[k]  <= c_d[k];
            end
         end
         if (vld_d[NSTAGES-1]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign bus.out_valid = vld_q[NSTAGES-1];
   assign bus.sum       = s_q[NSTAGES-1];
   assign bus.cout      = c_q[NSTAGES-1];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
